ps2_key_decoder: RTL and testbench

Downstream of the PS/2 receiver. Consumes the receiver's byte stream (low byte of `keycode` plus the one-cycle `oflag` strobe) and interprets Set-2 scan codes: make, break (`F0`) and extended (`E0`) prefixes. It suppresses typematic repeats and converts letter keys A–Z into 5-bit letter indices. Indices are buffered in a 4-entry FIFO with a valid/ready handshake toward the Enigma rotor core; Esc is passed on as a separate clear pulse.

---
 rtl/ps2_key_decoder_pkg.sv | 54 +++++
 rtl/ps2_key_decoder_if.sv | 21 ++
 rtl/ps2_key_decoder_fifo.sv | 76 +++++++
 rtl/ps2_key_decoder.sv | 119 +++++++++++
 tb/tb_ps2_key_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, prefix-state type and the Set-2 letter lookup
// for the PS/2 key decoder.
package ps2_pkg;

  localparam int unsigned LETTER_W = 5;

  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_ESC = 8'h76;

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } prefix_state_e;

  // Returns {is_letter, idx}; idx is 0 for A through 25 for Z.
  function automatic logic [LETTER_W:0] sc_to_letter(input logic [7:0] code);
    logic [LETTER_W:0] res;
    res = '0;
    case (code)
      8'h1C: res = {1'b1, 5'd0};
      8'h32: res = {1'b1, 5'd1};
      8'h21: res = {1'b1, 5'd2};
      8'h23: res = {1'b1, 5'd3};
      8'h24: res = {1'b1, 5'd4};
      8'h2B: res = {1'b1, 5'd5};
      8'h34: res = {1'b1, 5'd6};
      8'h33: res = {1'b1, 5'd7};
      8'h43: res = {1'b1, 5'd8};
      8'h3B: res = {1'b1, 5'd9};
      8'h42: res = {1'b1, 5'd10};
      8'h4B: res = {1'b1, 5'd11};
      8'h3A: res = {1'b1, 5'd12};
      8'h31: res = {1'b1, 5'd13};
      8'h44: res = {1'b1, 5'd14};
      8'h4D: res = {1'b1, 5'd15};
      8'h15: res = {1'b1, 5'd16};
      8'h2D: res = {1'b1, 5'd17};
      8'h1B: res = {1'b1, 5'd18};
      8'h2C: res = {1'b1, 5'd19};
      8'h3C: res = {1'b1, 5'd20};
      8'h2A: res = {1'b1, 5'd21};
      8'h1D: res = {1'b1, 5'd22};
      8'h22: res = {1'b1, 5'd23};
      8'h35: res = {1'b1, 5'd24};
      8'h1A: res = {1'b1, 5'd25};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Valid/ready letter stream from the key decoder toward the rotor core.
interface ps2_key_decoder_if;
  import ps2_pkg::*;

  logic [LETTER_W-1:0] out_letter;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_letter,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_letter,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// Show-ahead circular letter FIFO with flush and sticky overflow.
module key_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [Width-1:0]         o_data,
  output logic [$clog2(Depth):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntFull);
  assign w_pop     = i_pop && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CntOne;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CntOne;
      end
      if (i_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code interpreter: prefix FSM, typematic suppression, letter
// mapping into a small FIFO, and an Esc clear pulse.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              kcode,
  input  logic                    kvalid,
  ps2_key_decoder_if.master       out_if,
  output logic                    clear,
  output logic                    overflow
);

  prefix_state_e r_state;
  prefix_state_e w_state_next;

  logic [7:0]                r_held_code;
  logic                      r_held_v;
  logic                      r_clear;

  logic                      w_make;
  logic                      w_break;
  logic                      w_repeat;
  logic                      w_new_make;
  logic [LETTER_W:0]         w_map;
  logic                      w_push;
  logic                      w_flush;
  logic                      w_pop;
  logic [LETTER_W-1:0]       w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (kvalid) begin
      unique case (r_state)
        StIdle: begin
          if (kcode == SC_BRK) begin
            w_state_next = StBrk;
          end else if (kcode == SC_EXT) begin
            w_state_next = StExt;
          end
        end
        StBrk:    w_state_next = StIdle;
        StExt:    w_state_next = (kcode == SC_BRK) ? StExtBrk : StIdle;
        StExtBrk: w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_make  = 1'b0;
    w_break = 1'b0;
    if (kvalid) begin
      unique case (r_state)
        StIdle:  w_make  = (kcode != SC_BRK) && (kcode != SC_EXT);
        StBrk:   w_break = 1'b1;
        default: begin
          w_make  = 1'b0;
          w_break = 1'b0;
        end
      endcase
    end
  end

  assign w_repeat   = r_held_v && (kcode == r_held_code);
  assign w_new_make = w_make && !w_repeat;
  assign w_map      = sc_to_letter(kcode);
  assign w_push     = w_new_make && w_map[LETTER_W];
  assign w_flush    = w_new_make && (kcode == SC_ESC);
  assign w_pop      = out_if.out_valid && out_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held_code <= '0;
      r_held_v    <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_clear <= w_flush;
      if (w_new_make) begin
        r_held_code <= kcode;
        r_held_v    <= 1'b1;
      end else if (w_break && w_repeat) begin
        r_held_v <= 1'b0;
      end
    end
  end

  key_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (LETTER_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_data     (w_map[LETTER_W-1:0]),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_data     (w_head),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  assign out_if.out_letter = w_head;
  assign out_if.out_valid  = (w_count != '0);
  assign clear             = r_clear;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised and directed bench for ps2_key_decoder against a byte-level
// behavioural model of the key stream and letter queue.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] kcode = 8'h00;
  logic       kvalid = 1'b0;
  logic       clear;
  logic       overflow;

  ps2_key_decoder_if u_if ();

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kcode    (kcode),
    .kvalid   (kvalid),
    .out_if   (u_if),
    .clear    (clear),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] letter_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Model state
  logic [4:0] m_q [$];
  logic [4:0] popped [$];
  bit         m_ovf, m_clr, m_held_v, m_after_f0, m_after_e0;
  logic [7:0] m_held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int letter_idx(input logic [7:0] c);
    for (int i = 0; i < 26; i++) begin
      if (letter_codes[i] == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_clr = 0; m_held_v = 0; m_held = 8'h00;
    m_after_f0 = 0; m_after_e0 = 0;
  endtask

  task automatic model_edge(input logic kv, input logic [7:0] kc, input logic rdy);
    bit pop, push, flush;
    int li, pre;
    pop = (m_q.size() != 0) && rdy;
    push = 0; flush = 0; li = -1;
    m_clr = 0;
    if (kv) begin
      if (m_after_e0) begin
        if (!m_after_f0 && kc == 8'hF0) m_after_f0 = 1;
        else begin m_after_e0 = 0; m_after_f0 = 0; end
      end else if (m_after_f0) begin
        if (m_held_v && kc == m_held) m_held_v = 0;
        m_after_f0 = 0;
      end else if (kc == 8'hF0) begin
        m_after_f0 = 1;
      end else if (kc == 8'hE0) begin
        m_after_e0 = 1;
      end else if (!(m_held_v && kc == m_held)) begin
        m_held = kc; m_held_v = 1;
        li = letter_idx(kc);
        if (li >= 0) push = 1;
        else if (kc == 8'h76) flush = 1;
      end
    end
    if (flush) begin
      m_q.delete();
      m_clr = 1;
    end else begin
      pre = m_q.size();
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (pre == DEPTH && !pop) m_ovf = 1;
        else m_q.push_back(5'(li));
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("out_valid", 32'(u_if.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("out_letter", 32'(u_if.out_letter), 32'(m_q[0]));
    check_eq("clear", 32'(clear), 32'(m_clr));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    logic kv, rdy;
    logic [7:0] kc;
    kv = kvalid; kc = kcode; rdy = u_if.out_ready;
    if (rdy && u_if.out_valid) popped.push_back(u_if.out_letter);
    @(posedge clk);
    model_edge(kv, kc, rdy);
    #1;
    compare_outputs();
  endtask

  task automatic send_byte(input logic [7:0] c);
    kvalid = 1'b1; kcode = c;
    tick();
    kvalid = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] seq_a [15] = '{8'h15, 8'hF0, 8'h15, 8'h1D, 8'hF0, 8'h1D, 8'h24, 8'hF0,
                               8'h24, 8'h2D, 8'hF0, 8'h2D, 8'h2C, 8'hF0, 8'h2C};
    logic [4:0] exp_drain [4] = '{5'd16, 5'd22, 5'd4, 5'd17};
    logic [7:0] others [4] = '{8'h75, 8'h05, 8'h29, 8'h5A};
    logic [7:0] c;
    int sel;

    u_if.out_ready = 1'b1;
    model_reset();
    #2;
    check_eq("rst_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_letter", 32'(u_if.out_letter), 32'd0);
    check_eq("rst_clear", 32'(clear), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Make then break of A
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    // Typematic repeats, release, press again
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    // Extended arrow then R
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'h2D); send_byte(8'hF0); send_byte(8'h2D);

    // QWERT with consumer stalled
    u_if.out_ready = 1'b0;
    foreach (seq_a[i]) send_byte(seq_a[i]);
    check_eq("qwert_overflow", 32'(overflow), 32'd1);
    popped.delete();
    u_if.out_ready = 1'b1;
    repeat (6) tick();
    check_eq("drain_count", 32'(popped.size()), 32'd4);
    foreach (exp_drain[i]) begin
      if (i < popped.size()) check_eq("drain_letter", 32'(popped[i]), 32'(exp_drain[i]));
    end

    // Esc flushes two queued letters
    u_if.out_ready = 1'b0;
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h32); send_byte(8'hF0); send_byte(8'h32);
    kvalid = 1'b1; kcode = 8'h76;
    tick();
    kvalid = 1'b0;
    check_eq("esc_clear", 32'(clear), 32'd1);
    check_eq("esc_empty", 32'(u_if.out_valid), 32'd0);
    tick();
    check_eq("esc_clear_done", 32'(clear), 32'd0);
    send_byte(8'hF0); send_byte(8'h76);
    send_byte(8'h21);
    u_if.out_ready = 1'b1;
    repeat (2) tick();

    // Reset right after a lone break prefix
    send_byte(8'hF0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst2_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst2_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.out_ready = 1'b0;
    tick();
    send_byte(8'h1A);
    check_eq("z_valid", 32'(u_if.out_valid), 32'd1);
    check_eq("z_letter", 32'(u_if.out_letter), 32'd25);
    check_eq("z_overflow", 32'(overflow), 32'd0);

    // Random byte stream with random consumer readiness
    for (int n = 0; n < 1500; n++) begin
      u_if.out_ready = ($urandom_range(0, 2) != 0);
      if (!kvalid && $urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 99);
        if (sel < 50) c = letter_codes[$urandom_range(0, 25)];
        else if (sel < 72) c = 8'hF0;
        else if (sel < 82) c = 8'hE0;
        else if (sel < 87) c = 8'h76;
        else c = others[$urandom_range(0, 3)];
        kvalid = 1'b1; kcode = c;
      end else begin
        kvalid = 1'b0;
      end
      tick();
    end
    kvalid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
